// File: rtl/wave_decoder.sv
// Passive checker for the one-hot bouncing LED sweep bus: decodes lamp position
// and direction, locks onto a valid sweep and counts protocol violations.
module wave_decoder #(
  parameter int WIDTH    = 8,
  parameter int LOCK_LEN = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ce,
  input  logic [WIDTH-1:0] i_led,
  output logic [3:0]       o_index,
  output logic             o_dir,
  output logic             o_locked,
  output logic             o_err,
  output logic [7:0]       o_err_count,
  output logic [15:0]      o_sweeps
);

  typedef enum logic [1:0] {S_SEARCH, S_ACQUIRE, S_LOCKED} state_t;

  localparam logic [3:0] LAST_IDX    = 4'(WIDTH - 1);
  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_LEN);

  state_t      r_state, w_next_state;
  logic [3:0]  r_index, r_run;
  logic        r_dir, r_first, r_err, r_locked;
  logic [7:0]  r_err_count;
  logic [15:0] r_sweeps;

  logic [4:0]  w_ones;
  logic [3:0]  w_idx, w_expected, w_run_inc;
  logic        w_legal, w_adjacent, w_step_ok;
  logic        w_seed, w_advance, w_violation, w_sweep;

  always_comb begin
    w_ones = '0;
    w_idx  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (i_led[k]) begin
        w_ones = w_ones + 5'd1;
        w_idx  = 4'(k);
      end
    end
  end

  assign w_legal = (w_ones == 5'd1);

  // The stored index doubles as idx_prev: it only moves on legal samples.
  always_comb begin
    if (r_index == LAST_IDX)  w_expected = LAST_IDX - 4'd1;
    else if (r_index == 4'd0) w_expected = 4'd1;
    else if (r_dir)           w_expected = r_index - 4'd1;
    else                      w_expected = r_index + 4'd1;
  end

  // Right after a seed the direction is unknown, so either neighbour is accepted.
  assign w_adjacent = ({1'b0, w_idx} == ({1'b0, r_index} + 5'd1)) ||
                      ((r_index != 4'd0) && (w_idx == (r_index - 4'd1)));
  assign w_step_ok  = w_legal && (r_first ? w_adjacent : (w_idx == w_expected));
  assign w_run_inc  = r_run + 4'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_SEARCH;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_SEARCH: begin
        if (i_ce && w_legal) w_next_state = S_ACQUIRE;
      end
      S_ACQUIRE: begin
        if (i_ce) begin
          if (w_step_ok) begin
            if (w_run_inc == LOCK_TARGET) w_next_state = S_LOCKED;
          end else if (!w_legal) begin
            w_next_state = S_SEARCH;
          end
        end
      end
      S_LOCKED: begin
        if (i_ce && !w_step_ok) w_next_state = w_legal ? S_ACQUIRE : S_SEARCH;
      end
      default: w_next_state = S_SEARCH;
    endcase
  end

  always_comb begin
    w_seed      = i_ce && w_legal && ((r_state == S_SEARCH) || !w_step_ok);
    w_advance   = i_ce && w_step_ok && (r_state != S_SEARCH);
    w_violation = i_ce && (r_state == S_LOCKED) && !w_step_ok;
    w_sweep     = w_advance && (r_state == S_LOCKED) &&
                  (r_index == 4'd1) && (w_idx == 4'd0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_index     <= '0;
      r_dir       <= 1'b0;
      r_run       <= '0;
      r_first     <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
      r_err_count <= '0;
      r_sweeps    <= '0;
    end else begin
      r_err    <= w_violation;
      r_locked <= (w_next_state == S_LOCKED);
      if (i_ce && w_legal) begin
        r_index <= w_idx;
        r_dir   <= !(w_idx > r_index);
      end
      if (w_seed) begin
        r_run   <= '0;
        r_first <= 1'b1;
      end else if (w_advance && (r_state == S_ACQUIRE)) begin
        r_run   <= w_run_inc;
        r_first <= 1'b0;
      end
      if (w_violation && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
      if (w_sweep) r_sweeps <= r_sweeps + 16'd1;
    end
  end

  assign o_index     = r_index;
  assign o_dir       = r_dir;
  assign o_locked    = r_locked;
  assign o_err       = r_err;
  assign o_err_count = r_err_count;
  assign o_sweeps    = r_sweeps;

endmodule

// File: tb/tb_wave_decoder.sv
// Directed bench for wave_decoder (WIDTH=8, LOCK_LEN=4): sweep lock, violations,
// strobe gating, async reset and error-count saturation.
module tb_wave_decoder;

  logic        clock = 1'b0;
  logic        reset;
  logic        ce;
  logic [7:0]  led;
  logic [3:0]  index;
  logic        dir, locked, err;
  logic [7:0]  errCount;
  logic [15:0] sweeps;

  int checkCount = 0;
  int errorCount = 0;

  wave_decoder #(.WIDTH(8), .LOCK_LEN(4)) dut (
    .i_clk(clock), .i_reset(reset), .i_ce(ce), .i_led(led),
    .o_index(index), .o_dir(dir), .o_locked(locked), .o_err(err),
    .o_err_count(errCount), .o_sweeps(sweeps)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Drive away from the active edge, then sample 1 ns after it.
  task automatic applyStimulus(input logic ceIn, input logic [7:0] ledIn);
    @(negedge clock);
    ce  = ceIn;
    led = ledIn;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] ledOf(input int idx);
    logic [7:0] one;
    one = 8'd1;
    return one << idx;
  endfunction

  function automatic int sweepPos(input int k);
    int m;
    m = k % 14;
    return (m <= 7) ? m : 14 - m;
  endfunction

  initial begin
    int seq[];
    reset = 1'b1;
    ce    = 1'b0;
    led   = 8'h00;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_index", index, 0);
    checkOutput("reset_dir", dir, 0);
    checkOutput("reset_locked", locked, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_errcount", errCount, 0);
    checkOutput("reset_sweeps", sweeps, 0);
    @(negedge clock);
    reset = 1'b0;

    // Clean sweep: lock after the fifth sample, one sweep per 14 samples.
    for (int k = 0; k <= 28; k++) begin
      applyStimulus(1'b1, ledOf(sweepPos(k)));
      checkOutput($sformatf("sweep_index_%0d", k), index, sweepPos(k));
      checkOutput($sformatf("sweep_locked_%0d", k), locked, (k >= 4) ? 1 : 0);
      checkOutput($sformatf("sweep_err_%0d", k), err, 0);
      checkOutput($sformatf("sweep_count_%0d", k), sweeps, k / 14);
      if (k >= 1)
        checkOutput($sformatf("sweep_dir_%0d", k), dir,
                    (sweepPos(k) > sweepPos(k - 1)) ? 0 : 1);
    end

    applyStimulus(1'b1, 8'h02);
    applyStimulus(1'b1, 8'h04);
    applyStimulus(1'b1, 8'h03);
    checkOutput("multi_err", err, 1);
    checkOutput("multi_errcount", errCount, 1);
    checkOutput("multi_locked", locked, 0);
    checkOutput("multi_index_hold", index, 2);
    applyStimulus(1'b1, 8'h00);
    checkOutput("search_err_low", err, 0);
    checkOutput("search_index_hold", index, 2);
    applyStimulus(1'b1, 8'h10);
    checkOutput("reseed_index", index, 4);
    checkOutput("reseed_locked", locked, 0);
    applyStimulus(1'b1, 8'h20);
    applyStimulus(1'b1, 8'h40);
    applyStimulus(1'b1, 8'h80);
    checkOutput("relock_early", locked, 0);
    applyStimulus(1'b1, 8'h40);
    checkOutput("relock_done", locked, 1);
    checkOutput("relock_dir", dir, 1);
    checkOutput("relock_errcount", errCount, 1);

    seq = '{5, 4, 3, 2, 1, 0, 1, 2};
    foreach (seq[i]) applyStimulus(1'b1, ledOf(seq[i]));
    checkOutput("sweeps_three", sweeps, 3);
    checkOutput("up_dir", dir, 0);
    checkOutput("up_locked", locked, 1);
    applyStimulus(1'b1, 8'h10);
    checkOutput("skip_err", err, 1);
    checkOutput("skip_errcount", errCount, 2);
    checkOutput("skip_index", index, 4);
    checkOutput("skip_locked", locked, 0);
    seq = '{5, 6, 7};
    foreach (seq[i]) applyStimulus(1'b1, ledOf(seq[i]));
    checkOutput("skip_relock_early", locked, 0);
    checkOutput("skip_err_cleared", err, 0);
    applyStimulus(1'b1, 8'h40);
    checkOutput("skip_relock_done", locked, 1);
    checkOutput("pre_reset_sweeps", sweeps, 3);
    checkOutput("pre_reset_errcount", errCount, 2);

    // Reset asserted between edges must clear outputs without a clock.
    @(negedge clock);
    ce = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_index", index, 0);
    checkOutput("async_dir", dir, 0);
    checkOutput("async_locked", locked, 0);
    checkOutput("async_errcount", errCount, 0);
    checkOutput("async_sweeps", sweeps, 0);
    @(negedge clock);
    reset = 1'b0;

    for (int s = 0; s < 5; s++) begin
      applyStimulus(1'b1, ledOf(s));
      checkOutput($sformatf("strobe_index_%0d", s), index, s);
      checkOutput($sformatf("strobe_locked_%0d", s), locked, (s == 4) ? 1 : 0);
      applyStimulus(1'b0, 8'hA5);
      checkOutput($sformatf("idle_index_%0d", s), index, s);
      checkOutput($sformatf("idle_locked_%0d", s), locked, (s == 4) ? 1 : 0);
      checkOutput($sformatf("idle_err_%0d", s), err, 0);
    end

    // Repeated violations: the count saturates, the pulse does not.
    for (int v = 1; v <= 260; v++) begin
      applyStimulus(1'b1, 8'h00);
      checkOutput($sformatf("sat_err_%0d", v), err, 1);
      checkOutput($sformatf("sat_count_%0d", v), errCount, (v > 255) ? 255 : v);
      applyStimulus(1'b1, 8'h01);
      checkOutput($sformatf("sat_err_low_%0d", v), err, 0);
      for (int s = 1; s < 5; s++) applyStimulus(1'b1, ledOf(s));
      checkOutput($sformatf("sat_relock_%0d", v), locked, 1);
    end
    checkOutput("sat_final", errCount, 255);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/wave_decoder.md
# wave_decoder

Passive monitor on the LED sweep bus: samples the one-hot bouncing pattern (bit 0 → bit WIDTH-1 → bit 0, no repeat at the ends), decodes lamp position and sweep direction, locks onto a valid sweep and flags protocol violations. It sits on the consumer side of the LED wave generator and is used on-board as a self-check and in simulation as a bus checker.

## Interface
- WIDTH, 8: LED bus width; 2..16.
- LOCK_LEN, 4: consecutive correct steps needed in ACQUIRE before LOCKED; 1..15.
- i_clk  input  1  system clock, all logic on rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_ce  input  1  sample strobe; i_led is evaluated only on cycles with i_ce=1.
- i_led  input  WIDTH  LED bus being monitored.
- o_index  output  4  bit position of the last one-hot sample.
- o_dir  output  1  direction of the last step: 0 = up (toward MSB), 1 = down.
- o_locked  output  1  high while in LOCKED.
- o_err  output  1  one-cycle pulse on a sweep violation while LOCKED.
- o_err_count  output  8  violation count, saturating at 255.
- o_sweeps  output  16  completed full sweeps, wraps at 65535 → 0.

## Operation
- Sample legal iff exactly one bit of i_led set; idx = that bit position. Zero or multiple bits set = illegal.
- Expected next index from (idx_prev, dir): idx_prev = WIDTH-1 → WIDTH-2; idx_prev = 0 → 1; else dir=0 → idx_prev+1, dir=1 → idx_prev-1.
- Step legal iff sample is legal and idx == expected; after a legal step dir = 0 if idx > idx_prev, else 1.
- States (only change on i_ce=1 cycles):
  - SEARCH: legal sample → store idx, run=0, go ACQUIRE. Illegal → stay, no error.
  - ACQUIRE: first step after seeding accepts idx = idx_prev ± 1 (sets dir); later steps must equal expected. Legal step → run+1; run reaching LOCK_LEN → LOCKED. Failed step: legal sample re-seeds ACQUIRE (run=0, idx stored); illegal → SEARCH. No o_err in ACQUIRE.
  - LOCKED: legal step → stay. Failed step → o_err pulse, o_err_count+1 (saturating at 255), then re-seed ACQUIRE if sample legal, else SEARCH.
- o_sweeps increments in LOCKED on each legal step from index 1 to index 0.
- o_index, o_dir update on every legal sample in any state; hold otherwise.
- i_ce=0: no state, counter or output change; o_err low.

## Timing
- All outputs registered; response appears the cycle after the i_ce=1 sample edge (latency 1).
- o_locked rises the cycle after the LOCK_LEN-th legal step following the seed, i.e. LOCK_LEN+1 samples from the first legal sample.
- o_err high exactly one cycle per violation; o_locked falls in the same cycle o_err rises.
- Reset (async assert, any time, including mid-lock): state SEARCH, run=0, o_index=0, o_dir=0, o_locked=0, o_err=0, o_err_count=0, o_sweeps=0. First sample considered is the first i_ce=1 edge after deassertion.
- Saturated o_err_count stays 255 while o_err still pulses; o_sweeps 65535 + 1 → 0.

## Test plan
- Reset, i_ce=1, drive 01,02,04,…,80,40,…,02 repeating (WIDTH=8, LOCK_LEN=4) → o_locked high on cycle 5 after first sample, o_index follows 0..7..1, o_dir flips at 7 and 0, o_sweeps +1 every 14 samples, o_err never set.
- While locked, replace one 08 with 03 → single o_err pulse, o_err_count=1, o_locked=0, state SEARCH; relock 5 samples after next legal sample.
- While locked going up at index 2, drive 10 (skip) → o_err pulse, ACQUIRE seeded at 4, o_index=4; continued legal sweep relocks after 4 steps.
- Toggle i_ce every other cycle with bus held between strobes → identical lock/index behaviour per strobe, no errors; i_ce=0 with garbage on i_led → no change.
- Assert i_reset mid-lock with o_sweeps=3, o_err_count=2 → all outputs 0 asynchronously; resume sweep → normal relock.
- Force 260 violations → o_err_count stops at 255, o_err still pulses each time.
